// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// funct fields, ALU control codes and ALUOp classes.
package uc_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_ERR    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ULA_AND = 3'b000;
   localparam logic [2:0] ULA_OR  = 3'b001;
   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_SUB = 3'b110;
   localparam logic [2:0] ULA_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ula_dec.sv
// ALU control decoder: maps ALUOp class plus R-type funct to the 3-bit ALU
// operation, and flags whether the funct field is one we implement.
module ula_dec
   import uc_pkg::*;
(
   input  logic [1:0] alu_op_i,
   input  logic [5:0] funct_i,
   output logic [2:0] ula_ctrl_o,
   output logic       legal_o
);

   logic [2:0] funct_ula;

   // legal_o depends on funct alone so DECODE can screen R-types early
   always_comb begin
      funct_ula = ULA_ADD;
      legal_o   = 1'b1;
      case (funct_i)
         FN_ADD:  funct_ula = ULA_ADD;
         FN_SUB:  funct_ula = ULA_SUB;
         FN_AND:  funct_ula = ULA_AND;
         FN_OR:   funct_ula = ULA_OR;
         FN_SLT:  funct_ula = ULA_SLT;
         default: legal_o   = 1'b0;
      endcase
   end

   always_comb begin
      ula_ctrl_o = ULA_ADD;
      case (alu_op_i)
         ALUOP_ADD:   ula_ctrl_o = ULA_ADD;
         ALUOP_SUB:   ula_ctrl_o = ULA_SUB;
         ALUOP_FUNCT: ula_ctrl_o = funct_ula;
         default:     ula_ctrl_o = ULA_ADD;
      endcase
   end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle MIPS-lite control unit: Moore sequencing FSM over the IR opcode,
// with PCEn the only output that also looks at the ALU zero flag.
module uc_multiciclo
   import uc_pkg::*;
#(
   parameter int RESET_PC_STEP = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Z,
   output logic [2:0] ULActrl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       Err,
   output logic [3:0] Estado
);

   // The PC increment comes from the datapath constant; the step parameter is
   // documentation only and resolves to the same select either way.
   localparam logic [1:0] SRCB_PC_INC = (RESET_PC_STEP == 1) ? SRCB_ONE : SRCB_ONE;

   state_t     state_q, state_d;
   logic [1:0] alu_op;
   logic       ir_write, mem_write, reg_write, pc_write, branch;
   logic       funct_legal;

   ula_dec u_ula_dec (
      .alu_op_i   (alu_op),
      .funct_i    (Funct),
      .ula_ctrl_o (ULActrl),
      .legal_o    (funct_legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      alu_op    = ALUOP_ADD;
      ALUSrcA   = 1'b0;
      ALUSrcB   = SRCB_REG;
      IorD      = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      PCSrc     = PCSRC_ALU;
      pc_write  = 1'b0;
      branch    = 1'b0;
      Err       = 1'b0;
      case (state_q)
         S_FETCH: begin
            ALUSrcB  = SRCB_PC_INC;
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM;
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = funct_legal ? S_EXEC : S_ERR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ERR;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            MemtoReg  = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            IorD      = 1'b1;
            mem_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst    = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            PCSrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
            state_d = S_FETCH;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            PCSrc    = PCSRC_JUMP;
            pc_write = 1'b1;
            state_d  = S_FETCH;
         end
         S_ERR: begin
            Err     = 1'b1;
            state_d = S_ERR;
         end
         default: state_d = S_ERR;
      endcase
   end

   // Enables are masked by rst_n so an asserted reset kills writes at once.
   assign IRWrite  = ir_write  & rst_n;
   assign MemWrite = mem_write & rst_n;
   assign RegWrite = reg_write & rst_n;
   assign PCEn     = (pc_write | (branch & Z)) & rst_n;
   assign Estado   = state_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Scoreboard bench for uc_multiciclo: the driver queues the expected control
// word for each cycle and a monitor compares it against the DUT outputs.
module tb_uc_multiciclo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] Op = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Z = 1'b0;
   logic [2:0] ULActrl;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg;
   logic [1:0] PCSrc;
   logic       PCEn, Err;
   logic [3:0] Estado;

   uc_multiciclo #(.RESET_PC_STEP(1)) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Z(Z),
      .ULActrl(ULActrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .PCEn(PCEn),
      .Err(Err), .Estado(Estado)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tag;
      logic [19:0] vec;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   tag_n = 0;
   event probe_ev;

   localparam logic [2:0] U_AND = 3'b000, U_OR = 3'b001, U_ADD = 3'b010,
                          U_SUB = 3'b110, U_SLT = 3'b111;

   // Expected outputs per state, written out from the state table.
   function automatic logic [19:0] exp_vec(int st, logic [2:0] ula, logic z, logic rst);
      logic       srca, iord, irw, memw, regw, regdst, m2r, pcen, err;
      logic [1:0] srcb, pcsrc;
      logic [3:0] est;
      {srca, iord, irw, memw, regw, regdst, m2r, pcen, err} = '0;
      srcb = 2'b00; pcsrc = 2'b00;
      est  = 4'(st);
      case (st)
         0:  begin srcb = 2'b01; irw = 1'b1; pcen = 1'b1; end
         1:  srcb = 2'b10;
         2:  begin srca = 1'b1; srcb = 2'b10; end
         3:  iord = 1'b1;
         4:  begin m2r = 1'b1; regw = 1'b1; end
         5:  begin iord = 1'b1; memw = 1'b1; end
         6:  srca = 1'b1;
         7:  begin regdst = 1'b1; regw = 1'b1; end
         8:  begin srca = 1'b1; pcsrc = 2'b01; pcen = z; end
         9:  begin srca = 1'b1; srcb = 2'b10; end
         10: regw = 1'b1;
         11: begin pcsrc = 2'b10; pcen = 1'b1; end
         15: err = 1'b1;
         default: ;
      endcase
      if (!rst) begin irw = 1'b0; memw = 1'b0; regw = 1'b0; pcen = 1'b0; end
      return {est, ula, srca, srcb, iord, irw, memw, regw, regdst, m2r, pcsrc, pcen, err};
   endfunction

   task automatic push(int st, logic [2:0] ula);
      exp_t e;
      e.tag = tag_n;
      e.vec = exp_vec(st, ula, Z, rst_n);
      tag_n++;
      sb.push_back(e);
   endtask

   // Called at posedge+1; checks the current cycle and advances one clock.
   task automatic step(int st, logic [2:0] ula, logic z);
      Z = z;
      push(st, ula);
      @(posedge clk);
      #1;
   endtask

   // Immediate off-edge check, used around asynchronous reset changes.
   task automatic probe(int st, logic [2:0] ula);
      push(st, ula);
      #1;
      ->probe_ev;
      #1;
   endtask

   initial begin : monitor
      exp_t        e;
      logic [19:0] act;
      forever begin
         @(negedge clk or probe_ev);
         if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {Estado, ULActrl, ALUSrcA, ALUSrcB, IorD, IRWrite, MemWrite, RegWrite,
                   RegDst, MemtoReg, PCSrc, PCEn, Err};
            total++;
            if (act !== e.vec) begin
               bad++;
               $display("FAIL chk%0d ctl: got=%05h want=%05h (state got=%0d want=%0d)",
                        e.tag, act, e.vec, act[19:16], e.vec[19:16]);
            end else begin
               $display("ok   chk%0d state=%0d ctl=%05h", e.tag, act[19:16], act);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "bench timeout");
   end

   logic [5:0] fn_tab [4] = '{6'b101010, 6'b100100, 6'b100101, 6'b100010};
   logic [2:0] ul_tab [4] = '{3'b111, 3'b000, 3'b001, 3'b110};

   initial begin : driver
      Funct = 6'b100000;
      #2;
      probe(0, U_ADD);                  // held in reset: FETCH selects, enables gated
      @(posedge clk); #1;
      probe(0, U_ADD);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // add
      Op = 6'b000000; Funct = 6'b100000;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(6, U_ADD, 1); step(7, U_ADD, 0);
      // lw
      Op = 6'b100011;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(2, U_ADD, 0); step(3, U_ADD, 0); step(4, U_ADD, 0);
      // beq taken / not taken
      Op = 6'b000100;
      step(0, U_ADD, 0); step(1, U_ADD, 1); step(8, U_SUB, 1);
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(8, U_SUB, 0);
      // R-type funct sweep
      Op = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         Funct = fn_tab[i];
         step(0, U_ADD, 0); step(1, U_ADD, 0); step(6, ul_tab[i], 0); step(7, U_ADD, 0);
      end
      // addi and j
      Op = 6'b001000;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(9, U_ADD, 0); step(10, U_ADD, 0);
      Op = 6'b000010;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(11, U_ADD, 0);

      // illegal funct: ERR straight after DECODE, sticky for any Op
      Op = 6'b000000; Funct = 6'b100111;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(15, U_ADD, 0);
      Op = 6'b100011; step(15, U_ADD, 0);
      Op = 6'b000100; step(15, U_ADD, 1);
      Op = 6'b000010; step(15, U_ADD, 0);
      Z = 1'b0;
      rst_n = 1'b0;
      probe(0, U_ADD);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // illegal opcode
      Op = 6'b111111; Funct = 6'b100000;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(15, U_ADD, 0); step(15, U_ADD, 0);
      rst_n = 1'b0;
      probe(0, U_ADD);
      @(posedge clk); #1;
      probe(0, U_ADD);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // sw aborted by reset inside MEMWR
      Op = 6'b101011;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(2, U_ADD, 0);
      push(5, U_ADD);
      @(negedge clk); #2;
      rst_n = 1'b0;
      probe(0, U_ADD);
      @(posedge clk); #1;
      rst_n = 1'b1;
      Op = 6'b000010;
      step(0, U_ADD, 0); step(1, U_ADD, 0); step(11, U_ADD, 0);

      @(negedge clk); #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: got=%0d pending want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uc_multiciclo.md
# uc_multiciclo

Multicycle control unit for the 8-bit MIPS-lite datapath. It holds the instruction-sequencing FSM and decodes opcode and funct from the instruction register. Each cycle it drives the ALU's 3-bit `ULActrl` code, the operand-mux selects and the datapath write enables. It consumes the ALU zero flag `Z` to resolve `beq`, so it sits directly upstream of the ALU and steers everything around it.

## Interface
Reset and clocking are fixed: one clock; reset is asynchronous and active-low.

Parameters:
- `RESET_PC_STEP`, default 1: informational only; PC increment is supplied by the datapath through `ALUSrcB`=01. Must not change RTL behaviour.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Op` in 6: instruction bits [31:26], from the IR.
- `Funct` in 6: instruction bits [5:0], from the IR.
- `Z` in 1: ALU zero flag, same cycle.
- `ULActrl` out 3: ALU operation.
- `ALUSrcA` out 1: 0 selects PC, 1 selects register A.
- `ALUSrcB` out 2: 00 selects B, 01 selects constant 1, 10 selects SignImm.
- `IorD` out 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `IRWrite` out 1: IR load enable.
- `MemWrite` out 1: data memory write enable.
- `RegWrite` out 1: register file write enable.
- `RegDst` out 1: 1 selects rd, 0 selects rt.
- `MemtoReg` out 1: 1 selects the data register, 0 selects ALUOut.
- `PCSrc` out 2: 00 selects ALU result, 01 selects ALUOut, 10 selects jump target.
- `PCEn` out 1: PC load, computed as PCWrite | (Branch & Z).
- `Err` out 1: high while in the ERR state.
- `Estado` out 4: current state code, for debug.

## Operation
Outputs are Moore-style, decoded from the state register. The only exception is `PCEn`, which depends combinationally on `Z`.

`ULActrl` encoding:
- 000 AND
- 001 OR
- 010 ADD
- 110 SUB
- 111 SLT

ALUOp mapping:
- 00 gives ADD.
- 01 gives SUB.
- 10 decodes `Funct`: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.

State sequence:
- FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next state is DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute). Next state by `Op`:
  - 100011 or 101011 go to MEMADR.
  - 000000 goes to EXEC if `Funct` is legal, otherwise ERR.
  - 000100 goes to BRANCH.
  - 001000 goes to ADDIEX.
  - 000010 goes to JUMP.
  - Any other opcode goes to ERR.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD(3): IorD=1. Next is MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1. Next is FETCH.
- MEMWR(5): IorD=1, MemWrite=1. Next is FETCH.
- EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1. Next is FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next is FETCH.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDIWB.
- ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1. Next is FETCH.
- JUMP(11): PCSrc=10, PCWrite=1. Next is FETCH.
- ERR(15): all enables are 0 and Err=1. The state is sticky; only `rst_n` exits it.

Default rule: every signal not listed for a state is 0.

## Timing
- Cycles per instruction, FETCH included: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset:
  - While `rst_n`=0, the state is FETCH.
  - PCEn, IRWrite, MemWrite and RegWrite are gated to 0 by `rst_n`. Mux selects hold their FETCH values and `ULActrl` is 010.
  - The first rising edge after release executes FETCH.
  - Asserting reset mid-instruction aborts it immediately, with no partial write after assertion.
- `Z` is sampled combinationally in BRANCH; `PCEn` must settle within the same cycle.
- Illegal R-type `Funct` is detected in DECODE, never in EXEC. Unused state codes 12–14 go to ERR.

## Structure
- Package `uc_pkg` holds the state codes, opcode and funct constants, the `ULActrl` codes and the ALUOp codes.
- One sub-module, `ula_dec`: combinational ALUOp+Funct→ULActrl decoder, plus a `legal` flag used by DECODE.

## Test plan
- Reset, then `add` (Op=0, Funct=100000): states 0→1→6→7→0. ULActrl=010 in EXEC; RegWrite=1 only in ALUWB; RegDst=1.
- lw (Op=100011): five cycles 0,1,2,3,4. IorD=1 in MEMRD; MemtoReg=1 and RegWrite=1 in MEMWB.
- beq (Op=000100):
  - With Z=1, ULActrl=110 and PCEn=1 in BRANCH.
  - Repeat with Z=0; PCEn must be 0.
- `slt`/`and`/`or`/`sub` funct sweep: EXEC ULActrl must be 111/000/001/110. Funct=100111 must drive Err=1 after DECODE and stay there under any `Op`.
- Illegal Op=111111 goes to ERR with all enables 0. Pulsing `rst_n` low returns to FETCH with IRWrite=0 while held.
- Assert `rst_n` low mid-MEMWR: MemWrite drops asynchronously the same cycle, and restart is at FETCH.
